ram_sp_param: RTL
=================

RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits, legal range 1..64.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth DEPTH = 2**ADDR_W words (local, not overridable).
REQ-003 SHALL have parameter RD_MODE, default 0: same-address read/write collision, 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have parameter CLR_ON_RESET, default 1: 1 = run a zero-fill sweep automatically after reset; 0 = come out of reset idle.
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clr  input  1  synchronous request to zero-fill the whole array.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port addr  input  ADDR_W  shared read/write address.
REQ-011 SHALL have port din  input  DATA_W  write data.
REQ-012 SHALL have port dout  output  DATA_W  registered read data.
REQ-013 SHALL have port dout_vld  output  1  one-cycle pulse, dout updated by a read.
REQ-014 SHALL have port busy  output  1  high while a zero-fill sweep runs; we/re ignored.
REQ-015 SHALL have port clr_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and CLEAR, plus an ADDR_W-bit sweep pointer clr_ptr.
REQ-017 In IDLE with clr=1: next state CLEAR, clr_ptr<=0, dout<=0; any we/re in that cycle dropped (clr priority).
REQ-018 In CLEAR: each cycle writes 0 to mem[clr_ptr], clr_ptr increments; after the write at DEPTH-1 next state IDLE; sweep length exactly DEPTH cycles.
REQ-019 busy SHALL equal (state==CLEAR), registered; clr_done SHALL be high exactly in the first IDLE cycle after a sweep.
REQ-020 In CLEAR, we, re and clr SHALL be ignored: no array write from the ports, no dout update, dout_vld=0, sweep not restarted.
REQ-021 In IDLE, we=1 and clr=0: mem[addr]<=din at the rising edge.
REQ-022 In IDLE, re=1 and clr=0: dout<=mem[addr], dout_vld=1 the following cycle; read latency 1 clock.
REQ-023 re=0 or busy: dout SHALL hold its value; dout_vld=0.
REQ-024 we=1 and re=1 same address same cycle: dout = old word when RD_MODE=0, din when RD_MODE=1; write always occurs.
REQ-025 Back-to-back reads SHALL be supported at one per clock, dout_vld held high continuously.
REQ-026 clr_ptr SHALL not wrap beyond DEPTH-1 within one sweep; DEPTH=1 (ADDR_W=0 not allowed) is out of scope, ADDR_W>=1.

Reset
REQ-027 rst_n low SHALL asynchronously force dout=0, dout_vld=0, clr_done=0, clr_ptr=0.
REQ-028 rst_n low SHALL force state CLEAR and busy=1 when CLR_ON_RESET=1; state IDLE and busy=0 when CLR_ON_RESET=0.
REQ-029 Array contents SHALL not be reset asynchronously; when CLR_ON_RESET=1 all words read 0 after the post-reset sweep.
REQ-030 rst_n asserted mid-sweep or mid-read SHALL abort the operation; after release the REQ-028 behaviour applies and the sweep restarts from 0.

Verification (DATA_W=8, ADDR_W=4, CLR_ON_RESET=1 unless stated)
REQ-031 Release rst_n -> busy=1 for exactly 16 cycles, clr_done pulses once, then reads of all 16 addresses return 0x00 with dout_vld.
REQ-032 Write 0xA5 to addr 3, re at addr 3 next cycle -> dout=0xA5, dout_vld=1 one cycle after re, dout holds 0xA5 after re drops.
REQ-033 RD_MODE=0 vs 1: mem[7]=0x11, we=1 re=1 addr 7 din 0x22 -> dout=0x11 (mode 0) / 0x22 (mode 1); subsequent read returns 0x22.
REQ-034 Fill all words with 0xFF, pulse clr together with we addr 0 din 0x55 -> write dropped, 16-cycle sweep, we/re ignored during busy, all words read 0x00.
REQ-035 Assert rst_n low at sweep cycle 8 -> outputs zero immediately; after release sweep restarts, full 16 cycles, clr_done once.
REQ-036 CLR_ON_RESET=0: release rst_n -> busy=0 at once, write/read 0x3C at addr 15 succeeds first cycle.

Source files
------------

// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM with registered read data, selectable collision
// behaviour and a zero-fill sweep that runs on request or after reset.
module ram_sp_param #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int RD_MODE      = 0,
  parameter int CLR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam state_t RESET_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              port_en;
  logic              clr_start;
  logic              sweep_last;

  // Ports only act in IDLE, and a clear request wins over we/re in the same cycle.
  assign port_en    = (state == IDLE) && !clr;
  assign clr_start  = (state == IDLE) && clr;
  assign sweep_last = (state == CLEAR) && (clr_ptr == LAST);
  assign busy       = (state == CLEAR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr) next_state = CLEAR;
      CLEAR:   if (clr_ptr == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= sweep_last;
      if (clr_start)            clr_ptr <= '0;
      else if (state == CLEAR)  clr_ptr <= sweep_last ? '0 : clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= port_en && re;
      if (clr_start) begin
        dout <= '0;
      end else if (port_en && re) begin
        // Write-first mode forwards din on a same-cycle write to the shared address.
        dout <= (RD_MODE != 0 && we) ? din : mem[addr];
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; zeroing is done by
  // the sweep, one word per clock.
  always_ff @(posedge clk) begin
    if (state == CLEAR)     mem[clr_ptr] <= '0;
    else if (port_en && we) mem[addr]    <= din;
  end

endmodule
